// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//   Multi-cycle RV32M multiply/divide unit that sits beside the single-cycle
//   ALU. Multiplies use shift-add and divides use restoring division, each
//   producing one bit per cycle. The sequencer holds the core on `stall`
//   until the result reaches writeback in the DONE cycle.
//
// Ports
//   clk        core clock; all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   start      issue request, sampled only in IDLE
//   funct3     000 mul, 001 mulh, 010 mulhsu, 011 mulhu,
//              100 div, 101 divu, 110 rem, 111 remu
//   operand_a  rs1, captured at accept
//   operand_b  rs2, captured at accept
//   flush      abort any in-flight op (trap/redirect), no done follows
//   busy       op in progress (state not IDLE)
//   stall      hold PC/regfile write (combinational)
//   done       one-cycle pulse, result valid
//   result     result; holds its last value outside the done cycle
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6    // 2**CNT_W must exceed XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_IT  = CNT_W'(XLEN-1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op;
  logic [XLEN-1:0]   mcand;   // multiplicand magnitude, or divisor magnitude
  logic [XLEN-1:0]   hi;      // product high half, or partial remainder
  logic [XLEN-1:0]   lo;      // multiplier bits / product low, or dividend/quotient
  logic              neg_q;   // product or quotient must be negated
  logic              neg_r;   // remainder must be negated

  // -------------------------------------------------------------------------
  // Accept-time decode: operand signedness, magnitudes and fast-path cases
  // -------------------------------------------------------------------------
  logic            a_signed, b_signed;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            b_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    // mulh and signed div/rem treat both operands as signed; mulhsu only rs1.
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3[2] && !funct3[0]);
    b_signed = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
    sign_a   = a_signed && operand_a[XLEN-1];
    sign_b   = b_signed && operand_b[XLEN-1];
    abs_a    = sign_a ? -operand_a : operand_a;
    abs_b    = sign_b ? -operand_b : operand_b;

    b_zero   = (operand_b == '0);
    div_ovf  = !funct3[0] && (operand_a == INT_MIN) && (operand_b == '1);
    fast     = funct3[2] && (b_zero || div_ovf);

    // funct3[1] separates rem/remu from div/divu.
    if (b_zero)
      fast_res = funct3[1] ? operand_a : '1;
    else
      fast_res = funct3[1] ? '0 : operand_a;
  end

  // -------------------------------------------------------------------------
  // Per-cycle datapath steps
  // -------------------------------------------------------------------------
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_sh;
  logic [XLEN:0]   div_diff;
  logic            div_ge;

  always_comb begin
    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit is set; the carry shifts into the top of the product.
    mul_sum  = {1'b0, hi} + ({(XLEN+1){lo[0]}} & {1'b0, mcand});

    // Restoring divide: shift the next dividend bit into the remainder and
    // keep the difference only if it did not borrow.
    div_sh   = {hi, lo[XLEN-1]};
    div_diff = div_sh - {1'b0, mcand};
    div_ge   = !div_diff[XLEN];
  end

  // -------------------------------------------------------------------------
  // Sign fix-up and result selection
  // -------------------------------------------------------------------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   q_fix, r_fix;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod_fix = neg_q ? -{hi, lo} : {hi, lo};
    q_fix    = neg_q ? -lo : lo;
    r_fix    = neg_r ? -hi : hi;

    if (op[2])
      fix_res = op[1] ? r_fix : q_fix;
    else if (op[1:0] == 2'b00)
      fix_res = prod_fix[XLEN-1:0];
    else
      fix_res = prod_fix[2*XLEN-1:XLEN];
  end

  // Stall is released in DONE so writeback and PC advance happen there.
  assign stall = ((state == S_IDLE) && start) ||
                 (state == S_MUL) || (state == S_DIV) || (state == S_FIX);

  // -------------------------------------------------------------------------
  // Sequencer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op     <= '0;
      mcand  <= '0;
      hi     <= '0;
      lo     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else if (flush && (state != S_IDLE)) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          // A flush in the accept cycle kills the request before it starts.
          if (start && !flush) begin
            op    <= funct3;
            cnt   <= '0;
            mcand <= abs_b;
            hi    <= '0;
            lo    <= abs_a;
            neg_q <= sign_a ^ sign_b;
            neg_r <= sign_a;
            busy  <= 1'b1;
            if (fast) begin
              result <= fast_res;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              state  <= funct3[2] ? S_DIV : S_MUL;
            end
          end
        end

        S_MUL: begin
          {hi, lo} <= {mul_sum, lo[XLEN-1:1]};
          cnt      <= cnt + CNT_ONE;
          if (cnt == LAST_IT)
            state <= S_FIX;
        end

        S_DIV: begin
          hi  <= div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
          lo  <= {lo[XLEN-2:0], div_ge};
          cnt <= cnt + CNT_ONE;
          if (cnt == LAST_IT)
            state <= S_FIX;
        end

        S_FIX: begin
          result <= fix_res;
          done   <= 1'b1;
          state  <= S_DONE;
        end

        S_DONE: begin
          // A start seen here is dropped; the next op is taken from IDLE.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
//   Directed bench for muldiv_sequencer. An arithmetic reference model plus a
//   cycle-count timing model predicts busy/stall/done/result every cycle;
//   directed ops also check hand-computed results and latencies.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  muldiv_sequencer #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .funct3    (funct3),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- arithmetic reference (RV32M semantics) ----------------
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint     sa, sb, ub;
    logic [63:0] p;
    int         ia, ib;
    ia = a;
    ib = b;
    sa = longint'(ia);
    sb = longint'(ib);
    ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb;                 return p[63:32]; end
      3'd2: begin p = sa * ub;                 return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // ---------------- timing model ----------------
  // m_cyc: 0 when idle, else the index of the current cycle since accept
  // (1 = first cycle after the accept edge). Done occurs when m_cyc == m_lat.
  int          m_cyc = 0;
  int          m_lat = 0;
  logic [31:0] m_res = 0;
  logic [31:0] m_pend = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cyc = 0;
      m_lat = 0;
      m_res = 0;
    end else if (m_cyc != 0) begin
      if (flush || m_cyc == m_lat) m_cyc = 0;
      else begin
        m_cyc++;
        if (m_cyc == m_lat) m_res = m_pend;
      end
    end else if (start && !flush) begin
      m_pend = ref_op(funct3, operand_a, operand_b);
      m_lat  = is_fast(funct3, operand_a, operand_b) ? 1 : XLEN + 2;
      m_cyc  = 1;
      if (m_lat == 1) m_res = m_pend;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (armed) begin
      chk("busy",   {31'b0, busy},  {31'b0, m_cyc != 0});
      chk("done",   {31'b0, done},  {31'b0, m_cyc != 0 && m_cyc == m_lat});
      chk("stall",  {31'b0, stall},
          {31'b0, (m_cyc == 0 && start) || (m_cyc != 0 && m_cyc < m_lat)});
      chk("result", result, m_res);
    end
  end

  // ---------------- directed op ----------------
  // inj: 0 none, 1 re-assert start at cycle `at`, 2 flush at `at`, 3 reset at `at`
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, input int inj,
                       input int at, input string nm);
    int lat;
    int ndone;
    @(posedge clk); #1;
    start = 1; funct3 = f; operand_a = a; operand_b = b;
    #1 chk({nm, "_stall_at_start"}, {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    start = 0; funct3 = 3'($urandom); operand_a = $urandom; operand_b = $urandom;
    lat = 1;
    if (inj <= 1) begin
      while (!done && lat < 100) begin
        if (inj == 1 && lat == at) begin
          start = 1; funct3 = 3'b000; operand_a = 32'd3; operand_b = 32'd3;
        end
        @(posedge clk); #1;
        start = 0;
        lat++;
      end
      chk({nm, "_latency"}, lat, exp_lat);
      chk({nm, "_done"},    {31'b0, done}, 32'd1);
      chk({nm, "_result"},  result, exp);
      @(posedge clk); #1;
      chk({nm, "_busy_after"}, {31'b0, busy}, 32'd0);
    end else begin
      ndone = 0;
      while (lat < at) begin
        @(posedge clk); #1;
        lat++;
        ndone += int'(done);
      end
      if (inj == 2) flush = 1; else rst_n = 0;
      @(posedge clk); #1;
      flush = 0; rst_n = 1;
      chk({nm, "_busy_abort"}, {31'b0, busy}, 32'd0);
      chk({nm, "_done_abort"}, {31'b0, done}, 32'd0);
      if (inj == 3) chk({nm, "_result_reset"}, result, 32'd0);
      repeat (40) begin
        @(posedge clk); #1;
        ndone += int'(done);
      end
      chk({nm, "_no_done"}, ndone, 0);
    end
  endtask

  initial begin
    int lat;
    rst_n = 0; start = 0; flush = 0; funct3 = 0; operand_a = 0; operand_b = 0;

    // Model pins: hand-computed values.
    chk("model_mul",    ref_op(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    chk("model_mulhsu", ref_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
    chk("model_div",    ref_op(3'd4, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
    chk("model_rem",    ref_op(3'd6, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);

    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    armed = 1;
    chk("reset_busy",   {31'b0, busy}, 32'd0);
    chk("reset_done",   {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);

    do_op(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 0, 0, "mul");
    do_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34, 0, 0, "mulh");
    do_op(3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 34, 0, 0, "mulhu");
    do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 0, 0, "mulhsu");
    do_op(3'd5, 32'd100,      32'd7,        32'd14,       34, 0, 0, "divu");
    do_op(3'd7, 32'd100,      32'd7,        32'd2,        34, 0, 0, "remu");
    do_op(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 0, 0, "div_neg");
    do_op(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 0, 0, "rem_neg");
    do_op(3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  0, 0, "div_by0");
    do_op(3'd6, 32'd5,        32'd0,        32'd5,        1,  0, 0, "rem_by0");
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0, 0, "div_ovf");
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  0, 0, "rem_ovf");
    do_op(3'd5, 32'd100,      32'd7,        32'd14,       34, 1, 10, "divu_poke");
    do_op(3'd0, 32'd7,        32'd9,        32'd0,        0,  2, 5,  "mul_flush");
    do_op(3'd4, 32'd100,      32'd7,        32'd0,        0,  3, 20, "div_reset");
    do_op(3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 34, 0, 0, "mulh_after");

    // Start held through the done cycle: dropped there, taken the cycle after.
    @(posedge clk); #1;
    start = 1; funct3 = 3'd5; operand_a = 32'd100; operand_b = 32'd7;
    @(posedge clk); #1;
    start = 0;
    lat = 1;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("bk_first_result", result, 32'd14);
    start = 1; funct3 = 3'd3; operand_a = 32'h80000000; operand_b = 32'h80000000;
    @(posedge clk); #1;
    chk("bk_ignored_busy",  {31'b0, busy},  32'd0);
    chk("bk_ignored_stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    start = 0;
    lat = 1;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("bk_second_latency", lat, 34);
    chk("bk_second_result",  result, 32'h40000000);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide instructions, sitting beside the single-cycle ALU.
- Decode steers funct7=0000001 R-type ops here; the ALU handles everything else.
- Iterates shift-add multiply or restoring divide one bit per cycle.
- Holds the core through a stall output until the result is ready for writeback.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN
CNT_W, 6, width of iteration counter; must satisfy 2^CNT_W > XLEN

Ports:
clk  input  1  core clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
start  input  1  issue request; sampled only in IDLE
funct3  input  3  op: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
operand_a  input  XLEN  rs1 value; captured at accept
operand_b  input  XLEN  rs2 value; captured at accept
flush  input  1  abort in-flight op (trap/redirect)
busy  output  1  op in progress (state not IDLE)
stall  output  1  hold PC/regfile write; combinational
done  output  1  one-cycle pulse, result valid
result  output  XLEN  result; valid only while done=1, else holds last value

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, counter=0, busy=0, done=0, result=0, internal regs cleared. Reset mid-operation abandons the op; no done pulse follows.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE: start=1 at edge accepts the op. It latches funct3 and the operands and takes absolute values where the op is signed (mulh: both; mulhsu: operand_a only; div/rem: both). It records result sign and goes to MUL (funct3[2]=0) or DIV (funct3[2]=1), counter=0.
- Fast path at accept, DIV ops only, goes directly to DONE with result preloaded:
  - operand_b=0: div/divu -> all ones; rem/remu -> operand_a.
  - div/rem with operand_a=-2^(XLEN-1) and operand_b=-1: div -> operand_a; rem -> 0.
- MUL: 2*XLEN-bit product built by shift-add, one multiplier bit per cycle. counter increments; after XLEN iterations (counter=XLEN-1 at edge) go to FIX.
- DIV: restoring division, one quotient bit per cycle, same XLEN-iteration exit to FIX.
- FIX: apply two's-complement negation if the recorded sign is negative, then select the result:
  - mul: low half; mulh/mulhsu/mulhu: high half.
  - Quotient sign = sign_a XOR sign_b; remainder sign = sign_a.
  - Go to DONE.
- DONE: done=1, result valid for exactly this cycle; next edge -> IDLE.
- Latency from accept edge to done cycle: normal ops XLEN+2 cycles (34 for XLEN=32); fast path 1 cycle.
- Throughput: a start in the same cycle as done is ignored (DONE is not IDLE). Next op is accepted the cycle after done.
- stall = (state==IDLE && start) || state==MUL || state==DIV || state==FIX. stall=0 in the DONE cycle so writeback and PC advance happen there.
- start while busy: ignored, no effect on state or captured operands.
- flush: any state except IDLE -> IDLE at next edge, no done pulse. flush together with start in IDLE: start ignored. rst_n has priority over flush.
- Operands are not required stable after the accept edge.
- result holds its last value between ops; done is the only validity qualifier.

Test Plan:
- Reset then mul 7 * 0xFFFFFFFD (-3) -> stall high from the start cycle; done at cycle 34 after accept; result 0xFFFFFFEB; busy=0 the following cycle.
- mulh 0x80000000 * 0x80000000 -> 0x40000000; mulhu same operands -> 0x40000000; mulhsu 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
- divu 100/7 -> 14, remu -> 2; div 0xFFFFFFF9 (-7)/2 -> 0xFFFFFFFD; rem -> 0xFFFFFFFF.
- div 5/0 -> done one cycle after accept, result 0xFFFFFFFF; rem 5/0 -> 5; div 0x80000000/0xFFFFFFFF -> 0x80000000, rem -> 0, both 1-cycle latency.
- start re-asserted with different operands at cycle 10 of a divu 100/7 -> ignored, result still 14. Start asserted during the done cycle -> ignored; accepted the next cycle.
- flush at cycle 5 of a mul -> IDLE next edge, no done. rst_n=0 at cycle 20 of a div -> all outputs 0, no done. A new op afterwards completes correctly.
